flash_write_sequencer: RTL and testbench
========================================

# flash_write_sequencer

Sequencing controller for the board's SPI NOR flash (SPI Mode 0, active-low CS). Accepts single-byte read and write requests from the 6809 bus-interface logic over a req/ack handshake. Reads run as one READ (0x03) command. Writes run the full WREN (0x06), PAGE PROGRAM (0x02), RDSR (0x05) poll sequence until the flash clears WIP. The block owns the SPI pins and its own bit shifter, so the bus side holds the CPU in wait state until ack.

## Interface
- CLK_DIV, 2, system clocks per SCLK half-period (≥1)
- CS_GAP, 4, minimum clocks CS_n held high between commands (≥1)
- POLL_LIMIT, 16'd65535, maximum RDSR polls per write before timeout (≥1)
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- req  in  1  request; held high until ack
- req_we  in  1  1 = write byte, 0 = read byte; sampled with req
- req_addr  in  24  flash byte address; sampled with req
- req_wdata  in  8  write data; sampled with req
- ack  out  1  one-cycle completion pulse
- rdata  out  8  read data; valid from ack until next accepted read
- busy  out  1  high from accept cycle until ack cycle inclusive
- err_timeout  out  1  sticky; set when a write exhausts POLL_LIMIT; cleared on next accept
- spi_sclk  out  1  SPI clock, idle low
- spi_mosi  out  1  SPI data out, driven 0 when idle
- spi_cs_n  out  1  SPI chip select, active low
- spi_miso  in  1  SPI data in

## Operation
- Reset values, every output: ack=0, rdata=8'h00, busy=0, err_timeout=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1. State goes to IDLE. Reset wins over every other event.
- Reset mid-operation: on the next edge, CS_n goes high and SCLK goes low, with no ack. A partial program may be left in the flash, and that is acceptable.
- States: IDLE, READ, WREN, GAP_W, PROG, GAP_P, POLL, GAP_Q, DONE.
- IDLE: if req=1, latch addr/we/wdata, clear err_timeout, set busy. Go to READ (we=0) or WREN (we=1). req is ignored in every other state.
- READ: 40 bits. 0x03, then addr[23:0] MSB first, then 8 bits in on MISO MSB first into a shift register. Then rdata is loaded and the state goes to DONE.
- WREN: 8 bits of 0x06, then GAP_W.
- GAP_W: CS_GAP clocks, then PROG.
- PROG: 40 bits. 0x02, addr[23:0], then wdata MSB first. Then GAP_P. Poll counter is cleared.
- GAP_P: CS_GAP clocks, then POLL.
- POLL: 16 bits. 0x05, then 8 status bits in; the poll counter increments.
  - Status bit0 (WIP) = 0: go to DONE.
  - WIP = 1 and counter = POLL_LIMIT: set err_timeout and go to DONE.
  - Otherwise: go to GAP_Q.
- GAP_Q: CS_GAP clocks, then POLL.
- DONE: CS_n stays high for CS_GAP clocks. On the last of those clocks, ack=1 and busy is still 1. The state then goes to IDLE with busy=0.
- The earliest new accept is the cycle after ack. A req held continuously after ack is treated as a new request, so the requester must drop req on ack.
- Counters:
  - Bit counter is 6 bits.
  - Half-period counter is sized by $clog2(CLK_DIV+1).
  - Poll counter is 16 bits and saturates; it never wraps.

## Timing
- Each command starts with CS_n falling and MOSI presenting bit 7 of the opcode on the same clock edge.
- Each bit lasts 2·CLK_DIV clocks: CLK_DIV with SCLK low, then CLK_DIV with SCLK high.
- MISO is sampled on the clock where SCLK rises.
- MOSI changes only on the edge where SCLK falls, or at CS assertion.
- After the last bit's high phase, SCLK returns low and CS_n rises on the same edge.
- CS_n is low for exactly N·2·CLK_DIV clocks, where N = 8, 16 or 40.
- Read latency, accept edge to ack pulse: 1 + 40·2·CLK_DIV + CS_GAP clocks. With defaults this is 165.
- Write latency with k polls: 1 + (8+40+16k)·2·CLK_DIV + (2+k)·CS_GAP clocks.
  - k=1 with defaults: 1 + 64·4 + 3·4 = 269.
  - Add CS_GAP per extra poll beyond the first; this term is already included in the formula.
- MISO bits arriving during opcode/address phases are ignored.

## Test plan
- Read: req=1, we=0, addr=24'h000ABC; flash model returns 8'h5A. Required:
  - Opcode 0x03 then 24'h000ABC on MOSI.
  - CS_n low for 160 clocks.
  - ack exactly 165 clocks after accept, with rdata=8'h5A.
  - busy high for 166 cycles.
- Write, immediate ready: we=1, addr=24'h000123, wdata=8'hC3; status returns 8'h00. Required:
  - Command sequence 0x06 / 0x02,000123,C3 / 0x05.
  - CS_n high ≥4 clocks between commands.
  - ack at accept+269 clocks; err_timeout=0.
- Write, busy polls: status 8'h03 for 3 polls, then 8'h00. Required: exactly 4 RDSR commands, and ack at accept+269+3·(64+4) clocks.
- Timeout: POLL_LIMIT=3, status stuck at 8'h01. Required:
  - Exactly 3 RDSR commands, then ack with err_timeout=1.
  - The next accepted read clears err_timeout on its accept cycle.
- Reset mid-PROG, with reset low at bit 20. Required:
  - Next edge gives spi_cs_n=1, spi_sclk=0, busy=0; no ack is ever emitted.
  - A subsequent read completes normally.
- req held through ack, and req pulsed while busy: mid-operation req causes no accept; a held req is re-accepted exactly 1 cycle after ack.

Source files
------------

// File: rtl/flash_write_sequencer.sv
// rtl/flash_write_sequencer.sv - SPI NOR flash read/write command sequencer
//
// Purpose: turns single-byte read/write requests into SPI Mode 0 command
// sequences (READ, or WREN / PAGE PROGRAM / RDSR polling) with its own shifter.
// Ports:
//   clk, reset            system clock, synchronous active-low reset
//   req, req_we           request strobe (held until ack), 1 = write
//   req_addr, req_wdata   24-bit flash byte address, write data byte
//   ack                   one-cycle completion pulse
//   rdata                 last read byte
//   busy                  high from accept until ack inclusive
//   err_timeout           sticky write-poll timeout flag, cleared on accept
//   spi_sclk/mosi/cs_n    SPI outputs (idle: low / low / high)
//   spi_miso              SPI data in
module flash_write_sequencer #(
  parameter int          CLK_DIV    = 2,
  parameter int          CS_GAP     = 4,
  parameter logic [15:0] POLL_LIMIT = 16'd65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        err_timeout,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  input  logic        spi_miso
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  typedef enum logic [3:0] {
    IDLE, READ, WREN, GAP_W, PROG, GAP_P, POLL, GAP_Q, DONE
  } state_t;

  state_t        r_state, w_state, w_tgt;
  logic          r_ack, w_ack;
  logic [7:0]    r_rdata, w_rdata;
  logic          r_busy, w_busy;
  logic          r_err, w_err;
  logic          r_sclk, w_sclk;
  logic          r_mosi, w_mosi;
  logic          r_cs_n, w_cs_n;
  logic [23:0]   r_addr, w_addr;
  logic [7:0]    r_wdata, w_wdata;
  logic [39:0]   r_sh, w_sh;
  logic [7:0]    r_rx, w_rx;
  logic [HW-1:0] r_half, w_half;
  logic [5:0]    r_bit, w_bit;
  logic [GW-1:0] r_gap, w_gap;
  logic [15:0]   r_pcnt, w_pcnt, w_pinc;
  logic          w_start;

  // Outgoing frame, left-aligned so bit 39 goes out first.
  function automatic logic [39:0] frame(input state_t s, input logic [23:0] a,
                                        input logic [7:0] d);
    case (s)
      READ:    frame = {8'h03, a, 8'h00};
      WREN:    frame = {8'h06, 32'h0};
      PROG:    frame = {8'h02, a, d};
      default: frame = {8'h05, 32'h0};
    endcase
  endfunction

  function automatic logic [5:0] last_bit(input state_t s);
    case (s)
      READ, PROG: last_bit = 6'd39;
      WREN:       last_bit = 6'd7;
      default:    last_bit = 6'd15;
    endcase
  endfunction

  always_comb begin
    w_state = r_state;
    w_ack   = 1'b0;
    w_rdata = r_rdata;
    w_busy  = r_busy;
    w_err   = r_err;
    w_sclk  = r_sclk;
    w_mosi  = r_mosi;
    w_cs_n  = r_cs_n;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_sh    = r_sh;
    w_rx    = r_rx;
    w_half  = r_half;
    w_bit   = r_bit;
    w_gap   = r_gap;
    w_pcnt  = r_pcnt;
    w_start = 1'b0;
    w_tgt   = r_state;
    w_pinc  = (r_pcnt == 16'hFFFF) ? r_pcnt : r_pcnt + 16'd1;

    case (r_state)
      IDLE: begin
        w_busy = req;
        if (req) begin
          w_addr  = req_addr;
          w_wdata = req_wdata;
          w_err   = 1'b0;
          w_state = req_we ? WREN : READ;
        end
      end
      READ, WREN, PROG, POLL: begin
        if (r_cs_n) begin
          // Only reached on the first cycle after accept; gap states start
          // their own follow-on command.
          w_start = 1'b1;
        end else if (r_half != HALF_LAST) begin
          w_half = r_half + 1'b1;
        end else if (!r_sclk) begin
          w_sclk = 1'b1;
          w_half = '0;
          w_rx   = {r_rx[6:0], spi_miso};
        end else if (r_bit != last_bit(r_state)) begin
          w_sclk = 1'b0;
          w_half = '0;
          w_bit  = r_bit + 6'd1;
          w_sh   = {r_sh[38:0], r_sh[39]};
          w_mosi = r_sh[38];
        end else begin
          w_sclk = 1'b0;
          w_cs_n = 1'b1;
          w_mosi = 1'b0;
          w_half = '0;
          w_gap  = '0;
          case (r_state)
            READ: begin
              w_rdata = r_rx;
              w_state = DONE;
            end
            WREN: w_state = GAP_W;
            PROG: begin
              w_pcnt  = 16'd0;
              w_state = GAP_P;
            end
            default: begin
              w_pcnt = w_pinc;
              if (!r_rx[0]) begin
                w_state = DONE;
              end else if (w_pinc == POLL_LIMIT) begin
                w_err   = 1'b1;
                w_state = DONE;
              end else begin
                w_state = GAP_Q;
              end
            end
          endcase
        end
      end
      GAP_W, GAP_P, GAP_Q: begin
        if (r_gap != GAP_LAST) begin
          w_gap = r_gap + 1'b1;
        end else begin
          // CS falls on the edge that ends the gap, so the gap is exactly CS_GAP.
          w_start = 1'b1;
          w_tgt   = (r_state == GAP_W) ? PROG : POLL;
          w_state = w_tgt;
        end
      end
      DONE: begin
        if (r_gap != GAP_LAST) begin
          w_gap = r_gap + 1'b1;
        end else begin
          w_ack   = 1'b1;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_start) begin
      w_sh   = frame(w_tgt, r_addr, r_wdata);
      w_mosi = w_sh[39];
      w_cs_n = 1'b0;
      w_sclk = 1'b0;
      w_half = '0;
      w_bit  = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_addr  <= 24'h0;
      r_wdata <= 8'h00;
      r_sh    <= 40'h0;
      r_rx    <= 8'h00;
      r_half  <= '0;
      r_bit   <= 6'd0;
      r_gap   <= '0;
      r_pcnt  <= 16'd0;
    end else begin
      r_state <= w_state;
      r_ack   <= w_ack;
      r_rdata <= w_rdata;
      r_busy  <= w_busy;
      r_err   <= w_err;
      r_sclk  <= w_sclk;
      r_mosi  <= w_mosi;
      r_cs_n  <= w_cs_n;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_sh    <= w_sh;
      r_rx    <= w_rx;
      r_half  <= w_half;
      r_bit   <= w_bit;
      r_gap   <= w_gap;
      r_pcnt  <= w_pcnt;
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign busy        = r_busy;
  assign err_timeout = r_err;
  assign spi_sclk    = r_sclk;
  assign spi_mosi    = r_mosi;
  assign spi_cs_n    = r_cs_n;

endmodule

// File: tb/tb_flash_write_sequencer.sv
// tb/tb_flash_write_sequencer.sv - directed bench for flash_write_sequencer
module tb_flash_write_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, req_t = 1'b0;
  logic        req_we = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        miso = 1'b0, miso_t = 1'b0;

  logic ack, busy, err_timeout, spi_sclk, spi_mosi, spi_cs_n;
  logic [7:0] rdata;
  logic ack_t, busy_t, err_t, sclk_t, mosi_t, cs_n_t;
  logic [7:0] rdata_t;

  always #5 clk = ~clk;

  flash_write_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy),
    .err_timeout(err_timeout), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_miso(miso)
  );

  flash_write_sequencer #(.POLL_LIMIT(16'd3)) dut_t (
    .clk(clk), .reset(reset), .req(req_t), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack_t), .rdata(rdata_t), .busy(busy_t),
    .err_timeout(err_t), .spi_sclk(sclk_t), .spi_mosi(mosi_t),
    .spi_cs_n(cs_n_t), .spi_miso(miso_t)
  );

  int vectors = 0;
  int miscompares = 0;

  // Flash model for dut: logs each command, answers READ and RDSR.
  logic [7:0]  rd_byte = 8'h00;
  int          busy_polls = 0;
  int          polls = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;
  int          nb = 0, lowcnt = 0, hicnt = 0, gap_min = 1000, ncmd = 0;
  logic [39:0] mbits = 40'h0;
  logic [7:0]  op = 8'h00, stat = 8'h00;
  int          log_len [16];
  int          log_low [16];
  logic [39:0] log_bits [16];

  always @(negedge clk) begin
    if (prev_cs && !spi_cs_n) begin
      if (ncmd > 0 && hicnt < gap_min) gap_min = hicnt;
      nb = 0; lowcnt = 0; mbits = 40'h0; op = 8'h00; miso = 1'b0;
    end
    if (!prev_cs && spi_cs_n) begin
      if (ncmd < 16) begin
        log_len[ncmd] = nb; log_low[ncmd] = lowcnt; log_bits[ncmd] = mbits;
      end
      ncmd++;
      hicnt = 0;
    end
    if (!spi_cs_n) begin
      lowcnt++;
      if (!prev_sclk && spi_sclk) begin
        mbits = {mbits[38:0], spi_mosi};
        nb++;
        if (nb == 8) begin
          op = mbits[7:0];
          if (op == 8'h05) begin
            stat = (polls < busy_polls) ? 8'h03 : 8'h00;
            polls++;
          end
        end
      end else if (prev_sclk && !spi_sclk) begin
        if (op == 8'h03 && nb >= 32 && nb < 40) miso = rd_byte[3'(39 - nb)];
        else if (op == 8'h05 && nb >= 8 && nb < 16) miso = stat[3'(15 - nb)];
        else miso = 1'b0;
      end
    end else begin
      hicnt++;
    end
    prev_cs = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  // Flash model for dut_t: status stuck at 8'h01, reads return 8'h00.
  logic       prev_cs_t = 1'b1, prev_sclk_t = 1'b0;
  int         nb_t = 0, polls_t = 0;
  logic [7:0] bits_t = 8'h0, op_t = 8'h0;

  always @(negedge clk) begin
    if (prev_cs_t && !cs_n_t) begin
      nb_t = 0; op_t = 8'h00; miso_t = 1'b0;
    end
    if (!cs_n_t) begin
      if (!prev_sclk_t && sclk_t) begin
        bits_t = {bits_t[6:0], mosi_t};
        nb_t++;
        if (nb_t == 8) begin
          op_t = bits_t;
          if (op_t == 8'h05) polls_t++;
        end
      end else if (prev_sclk_t && !sclk_t) begin
        miso_t = (op_t == 8'h05 && nb_t == 15);
      end
    end
    prev_cs_t = cs_n_t;
    prev_sclk_t = sclk_t;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int sel, input logic we, input logic [23:0] a,
                       input logic [7:0] d);
    @(posedge clk); #1;
    req_we = we; req_addr = a; req_wdata = d;
    if (sel == 0) req = 1'b1; else req_t = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input int sel, input bit hold, input int pulse_at,
                          output int lat, output int bcnt);
    lat = -1;
    bcnt = ((sel == 0) ? busy : busy_t) ? 1 : 0;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      if (pulse_at > 0) begin
        if (k == 1) req = 1'b0;
        if (k == pulse_at) req = 1'b1;
        if (k == pulse_at + 3) req = 1'b0;
      end
      if ((sel == 0) ? busy : busy_t) bcnt++;
      if ((sel == 0) ? ack : ack_t) begin
        lat = k;
        if (!hold) begin req = 1'b0; req_t = 1'b0; end
        break;
      end
    end
  endtask

  int lat, bcnt, acks;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_cs_n", spi_cs_n, 1);
    reset = 1'b1;

    // Read 0x000ABC -> 0x5A
    rd_byte = 8'h5A; ncmd = 0;
    start(0, 1'b0, 24'h000ABC, 8'h00);
    wait_ack(0, 1'b0, 0, lat, bcnt);
    chk("rd_latency", lat, 165);
    chk("rd_busy_cycles", bcnt, 166);
    chk("rd_rdata", rdata, 8'h5A);
    chk("rd_ncmd", ncmd, 1);
    chk("rd_cmd_bits", log_bits[0][39:8], {8'h03, 24'h000ABC});
    chk("rd_cmd_len", log_len[0], 40);
    chk("rd_cs_low", log_low[0], 160);
    @(posedge clk); #1;
    chk("rd_busy_after", busy, 0);
    chk("rd_ack_after", ack, 0);

    // Write, flash ready on first poll
    busy_polls = 0; polls = 0; ncmd = 0; gap_min = 1000;
    start(0, 1'b1, 24'h000123, 8'hC3);
    wait_ack(0, 1'b0, 0, lat, bcnt);
    chk("wr_latency", lat, 269);
    chk("wr_err", err_timeout, 0);
    chk("wr_ncmd", ncmd, 3);
    chk("wr_wren", {log_len[0], 24'h0, log_bits[0][7:0]}, {32'd8, 24'h0, 8'h06});
    chk("wr_prog", log_bits[1], {8'h02, 24'h000123, 8'hC3});
    chk("wr_prog_low", log_low[1], 160);
    chk("wr_rdsr", {log_len[2], 16'h0, log_bits[2][15:8]}, {32'd16, 16'h0, 8'h05});
    chk("wr_gap_ge4", gap_min >= 4, 1);
    chk("wr_polls", polls, 1);

    // Write, WIP set for three polls
    busy_polls = 3; polls = 0; ncmd = 0;
    start(0, 1'b1, 24'h000200, 8'h11);
    wait_ack(0, 1'b0, 0, lat, bcnt);
    chk("wrp_latency", lat, 269 + 3 * 68);
    chk("wrp_polls", polls, 4);
    chk("wrp_ncmd", ncmd, 6);
    chk("wrp_err", err_timeout, 0);
    busy_polls = 0;

    // Timeout with POLL_LIMIT=3 on the second instance
    polls_t = 0;
    start(1, 1'b1, 24'h000123, 8'hC3);
    wait_ack(1, 1'b0, 0, lat, bcnt);
    chk("to_latency", lat, 1 + (8 + 40 + 48) * 4 + 5 * 4);
    chk("to_err", err_t, 1);
    chk("to_polls", polls_t, 3);
    @(posedge clk); #1;
    chk("to_err_sticky", err_t, 1);
    start(1, 1'b0, 24'h000ABC, 8'h00);
    chk("to_err_cleared", err_t, 0);
    wait_ack(1, 1'b0, 0, lat, bcnt);
    chk("to_read_latency", lat, 165);

    // Reset during PROG at bit 20
    ncmd = 0;
    start(0, 1'b1, 24'h000456, 8'h5A);
    lat = -1;
    for (int k = 0; k < 1000; k++) begin
      if (ncmd == 1 && !spi_cs_n && nb >= 20) begin lat = k; break; end
      @(posedge clk); #1;
    end
    chk("rstmid_reach_bit20", lat >= 0, 1);
    reset = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_cs_n", spi_cs_n, 1);
    chk("rstmid_sclk", spi_sclk, 0);
    chk("rstmid_busy", busy, 0);
    acks = ack ? 1 : 0;
    reset = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("rstmid_no_ack", acks, 0);
    rd_byte = 8'h3C;
    start(0, 1'b0, 24'h00F00D, 8'h00);
    wait_ack(0, 1'b0, 0, lat, bcnt);
    chk("rstmid_read_lat", lat, 165);
    chk("rstmid_read_data", rdata, 8'h3C);

    // req pulsed mid-operation is ignored
    rd_byte = 8'hA5;
    start(0, 1'b0, 24'h000010, 8'h00);
    wait_ack(0, 1'b0, 50, lat, bcnt);
    chk("pulse_latency", lat, 165);
    chk("pulse_rdata", rdata, 8'hA5);
    @(posedge clk); #1;
    chk("pulse_busy_after", busy, 0);
    @(posedge clk); #1;
    chk("pulse_cs_idle", spi_cs_n, 1);

    // req held through ack is re-accepted the next cycle
    start(0, 1'b0, 24'h000020, 8'h00);
    wait_ack(0, 1'b1, 0, lat, bcnt);
    chk("hold_latency", lat, 165);
    @(posedge clk); #1;
    chk("hold_reaccept_busy", busy, 1);
    chk("hold_ack_drop", ack, 0);
    req = 1'b0;
    wait_ack(0, 1'b0, 0, lat, bcnt);
    chk("hold_second_latency", lat, 165);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
